// File: rtl/xvc_seq_pkg.sv
// Shared types and default timing constants for the reset/start sequencer.
package xvc_seq_pkg;

  typedef enum logic [2:0] {
    PHY_RST,
    SETTLE,
    START,
    RUN,
    DONE
  } seq_state_t;

  localparam int unsigned DEF_RESET_CYCLES  = 1000;
  localparam int unsigned DEF_SETTLE_CYCLES = 5000;
  localparam int unsigned DEF_WDOG_CYCLES   = 2**24;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/xvc_seq_counter.sv
// Clearable up-counter with terminal-count compare, shared by all timed sequencer phases.
module xvc_seq_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] terminal,
  output logic             tc
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)       count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + CNT_W'(1);
  end

  assign tc = enable && (count == terminal);

endmodule

// File: rtl/xvc_reset_start_sequencer.sv
// PHY reset / settle / kernel start sequencer with done collection.
// Optional RUN watchdog enabled by defining XVC_SEQ_WATCHDOG_EN.
module xvc_reset_start_sequencer
  import xvc_seq_pkg::*;
#(
  parameter int unsigned NUM_CH        = 1,
  parameter int unsigned RESET_CYCLES  = DEF_RESET_CYCLES,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned WDOG_CYCLES   = DEF_WDOG_CYCLES
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              soft_reset,
  input  logic              run_req,
  input  logic [NUM_CH-1:0] done_port,
  output logic              eth_reset_n,
  output logic              phy_ready,
  output logic [NUM_CH-1:0] start_port,
  output logic [NUM_CH-1:0] done_mask,
  output logic              all_done,
  output logic              timeout
);

  localparam int unsigned CNT_W = $clog2(max3(RESET_CYCLES, SETTLE_CYCLES, WDOG_CYCLES)) + 1;

  if (NUM_CH == 0 || NUM_CH > 32) begin : g_bad_num_ch
    $error("NUM_CH must be in 1..32");
  end
  if (RESET_CYCLES == 0) begin : g_bad_reset_cycles
    $error("RESET_CYCLES must be >= 1");
  end
  if (SETTLE_CYCLES == 0) begin : g_bad_settle_cycles
    $error("SETTLE_CYCLES must be >= 1");
  end

  seq_state_t        state_q, state_d;
  logic              cnt_en, cnt_clr, cnt_tc;
  logic [CNT_W-1:0]  cnt_term;
  logic [NUM_CH-1:0] hit;
  logic              complete;

  logic              eth_reset_n_d, phy_ready_d, all_done_d;
  logic [NUM_CH-1:0] start_port_d, done_mask_d;

  assign hit      = done_mask | done_port;
  assign complete = &hit;

  // One counter serves every timed phase; it restarts from zero on each state change.
  always_comb begin
    cnt_en   = 1'b0;
    cnt_term = '0;
    case (state_q)
      PHY_RST: begin
        cnt_en   = 1'b1;
        cnt_term = CNT_W'(RESET_CYCLES - 1);
      end
      SETTLE: begin
        cnt_en   = 1'b1;
        cnt_term = CNT_W'(SETTLE_CYCLES - 1);
      end
`ifdef XVC_SEQ_WATCHDOG_EN
      RUN: begin
        cnt_en   = 1'b1;
        cnt_term = CNT_W'(WDOG_CYCLES - 1);
      end
`endif
      default: ;
    endcase
  end

  assign cnt_clr = soft_reset || (state_d != state_q);

  xvc_seq_counter #(.CNT_W(CNT_W)) u_counter (
    .clock    (clock),
    .reset    (reset),
    .clear    (cnt_clr),
    .enable   (cnt_en),
    .terminal (cnt_term),
    .tc       (cnt_tc)
  );

  always_comb begin
    state_d = state_q;
    if (soft_reset) begin
      state_d = PHY_RST;
    end else begin
      case (state_q)
        PHY_RST: if (cnt_tc) state_d = SETTLE;
        SETTLE:  if (cnt_tc) state_d = START;
        START:   state_d = complete ? DONE : RUN;
        RUN: begin
          if (complete) state_d = DONE;
`ifdef XVC_SEQ_WATCHDOG_EN
          else if (cnt_tc) state_d = DONE;
`endif
        end
        DONE:    if (run_req) state_d = START;
        default: state_d = PHY_RST;
      endcase
    end
  end

`ifdef XVC_SEQ_WATCHDOG_EN
  logic timeout_d;
`endif

  always_comb begin
    eth_reset_n_d = eth_reset_n;
    phy_ready_d   = phy_ready;
    start_port_d  = '0;
    done_mask_d   = done_mask;
    all_done_d    = all_done;
`ifdef XVC_SEQ_WATCHDOG_EN
    timeout_d     = timeout;
`endif
    if (soft_reset) begin
      eth_reset_n_d = 1'b0;
      phy_ready_d   = 1'b0;
      done_mask_d   = '0;
      all_done_d    = 1'b0;
`ifdef XVC_SEQ_WATCHDOG_EN
      timeout_d     = 1'b0;
`endif
    end else begin
      case (state_q)
        PHY_RST: if (cnt_tc) eth_reset_n_d = 1'b1;
        SETTLE: begin
          if (cnt_tc) begin
            phy_ready_d  = 1'b1;
            start_port_d = '1;
          end
        end
        START: begin
          done_mask_d = hit;
          if (complete) all_done_d = 1'b1;
        end
        RUN: begin
          done_mask_d = hit;
          if (complete) all_done_d = 1'b1;
`ifdef XVC_SEQ_WATCHDOG_EN
          else if (cnt_tc) timeout_d = 1'b1;
`endif
        end
        DONE: begin
          if (run_req) begin
            done_mask_d  = '0;
            all_done_d   = 1'b0;
            start_port_d = '1;
`ifdef XVC_SEQ_WATCHDOG_EN
            timeout_d    = 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= PHY_RST;
      eth_reset_n <= 1'b0;
      phy_ready   <= 1'b0;
      start_port  <= '0;
      done_mask   <= '0;
      all_done    <= 1'b0;
    end else begin
      state_q     <= state_d;
      eth_reset_n <= eth_reset_n_d;
      phy_ready   <= phy_ready_d;
      start_port  <= start_port_d;
      done_mask   <= done_mask_d;
      all_done    <= all_done_d;
    end
  end

`ifdef XVC_SEQ_WATCHDOG_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) timeout <= 1'b0;
    else       timeout <= timeout_d;
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_xvc_reset_start_sequencer.sv
// Scoreboard bench for xvc_reset_start_sequencer (NUM_CH=2, RESET=4, SETTLE=3, WDOG=10).
module tb_xvc_reset_start_sequencer;

  localparam int unsigned NUM_CH = 2;
  localparam int unsigned RC     = 4;
  localparam int unsigned SC     = 3;
  localparam int unsigned WC     = 10;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        soft_reset = 1'b0;
  logic        run_req = 1'b0;
  logic [1:0]  done_port = 2'b00;
  logic        eth_reset_n, phy_ready, all_done, timeout;
  logic [1:0]  start_port, done_mask;

  typedef struct packed {
    logic       eth;
    logic       phy;
    logic [1:0] start;
    logic [1:0] mask;
    logic       all_d;
    logic       to;
  } snap_t;

  snap_t obs;
  snap_t exp_s;
  snap_t sb[$];
  int    checks = 0;
  int    errors = 0;

  assign obs = {eth_reset_n, phy_ready, start_port, done_mask, all_done, timeout};

  xvc_reset_start_sequencer #(
    .NUM_CH        (NUM_CH),
    .RESET_CYCLES  (RC),
    .SETTLE_CYCLES (SC),
    .WDOG_CYCLES   (WC)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .soft_reset  (soft_reset),
    .run_req     (run_req),
    .done_port   (done_port),
    .eth_reset_n (eth_reset_n),
    .phy_ready   (phy_ready),
    .start_port  (start_port),
    .done_mask   (done_mask),
    .all_done    (all_done),
    .timeout     (timeout)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, limit 1000000 ns");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic eth, input logic phy, input logic [1:0] start,
                      input logic [1:0] mask, input logic all_d, input logic to);
    sb.push_back({eth, phy, start, mask, all_d, to});
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    push(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    tick();
    exp_s = sb.pop_front();
    checks++;
    if (obs !== exp_s) begin
      errors++;
      $display("FAIL reset_state: got %b want %b", obs, exp_s);
    end
    reset = 1'b0;
  endtask

  // Walks edges 1..n after a (soft) reset release; the start pulse sits on edge RC+SC.
  task automatic run_bringup(input string name, input int n);
    for (int e = 1; e <= n; e++)
      push(e >= RC, e >= RC + SC, (e == RC + SC) ? 2'b11 : 2'b00, 2'b00, 1'b0, 1'b0);
    for (int e = 1; e <= n; e++) begin
      tick();
      exp_s = sb.pop_front();
      checks++;
      if (obs !== exp_s) begin
        errors++;
        $display("FAIL %s edge %0d: got %b want %b", name, e, obs, exp_s);
      end
    end
  endtask

  task automatic test_bringup();
    run_bringup("bringup", 8);
  endtask

  task automatic test_run_collect();
    logic [1:0] d_tab[5]  = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b00};
    logic [1:0] m_tab[5]  = '{2'b01, 2'b01, 2'b01, 2'b11, 2'b11};
    logic       a_tab[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) push(1'b1, 1'b1, 2'b00, m_tab[i], a_tab[i], 1'b0);
    for (int i = 0; i < 5; i++) begin
      done_port = d_tab[i];
      tick();
      exp_s = sb.pop_front();
      checks++;
      if (obs !== exp_s) begin
        errors++;
        $display("FAIL run_collect step %0d: got %b want %b", i, obs, exp_s);
      end
    end
    done_port = 2'b00;
  endtask

  task automatic test_rerun();
    logic rq_tab[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [1:0] d_tab[4] = '{2'b11, 2'b00, 2'b00, 2'b00};
    push(1'b1, 1'b1, 2'b11, 2'b00, 1'b0, 1'b0);
    push(1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0);
    push(1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0);
    push(1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run_req   = rq_tab[i];
      done_port = d_tab[i];
      tick();
      exp_s = sb.pop_front();
      checks++;
      if (obs !== exp_s) begin
        errors++;
        $display("FAIL rerun step %0d: got %b want %b", i, obs, exp_s);
      end
    end
  endtask

  task automatic test_start_done();
    logic rq_tab[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0] d_tab[4] = '{2'b11, 2'b00, 2'b11, 2'b00};
    push(1'b1, 1'b1, 2'b00, 2'b11, 1'b1, 1'b0);
    push(1'b1, 1'b1, 2'b11, 2'b00, 1'b0, 1'b0);
    push(1'b1, 1'b1, 2'b00, 2'b11, 1'b1, 1'b0);
    push(1'b1, 1'b1, 2'b00, 2'b11, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run_req   = rq_tab[i];
      done_port = d_tab[i];
      tick();
      exp_s = sb.pop_front();
      checks++;
      if (obs !== exp_s) begin
        errors++;
        $display("FAIL start_done step %0d: got %b want %b", i, obs, exp_s);
      end
    end
    run_req   = 1'b0;
    done_port = 2'b00;
  endtask

  task automatic test_soft_reset();
    soft_reset = 1'b1;
    run_req    = 1'b1;
    push(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    tick();
    exp_s = sb.pop_front();
    checks++;
    if (obs !== exp_s) begin
      errors++;
      $display("FAIL soft_reset_done: got %b want %b", obs, exp_s);
    end
    soft_reset = 1'b0;
    run_req    = 1'b0;
    run_bringup("soft_partial", 6);
    soft_reset = 1'b1;
    push(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    tick();
    exp_s = sb.pop_front();
    checks++;
    if (obs !== exp_s) begin
      errors++;
      $display("FAIL soft_reset_settle: got %b want %b", obs, exp_s);
    end
    soft_reset = 1'b0;
    run_bringup("soft_rerun", 8);
  endtask

  task automatic test_watchdog();
`ifdef XVC_SEQ_WATCHDOG_EN
    localparam int N = WC + 1;
`else
    localparam int N = 100;
`endif
    done_port = 2'b01;
    for (int k = 1; k <= N; k++) begin
`ifdef XVC_SEQ_WATCHDOG_EN
      push(1'b1, 1'b1, 2'b00, 2'b01, 1'b0, k >= WC);
`else
      push(1'b1, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0);
`endif
    end
    for (int k = 1; k <= N; k++) begin
      tick();
      exp_s = sb.pop_front();
      checks++;
      if (obs !== exp_s) begin
        errors++;
        $display("FAIL watchdog run clk %0d: got %b want %b", k, obs, exp_s);
      end
    end
    run_req   = 1'b1;
    done_port = 2'b00;
`ifdef XVC_SEQ_WATCHDOG_EN
    push(1'b1, 1'b1, 2'b11, 2'b00, 1'b0, 1'b0);
`else
    push(1'b1, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0);
`endif
    tick();
    exp_s = sb.pop_front();
    checks++;
    if (obs !== exp_s) begin
      errors++;
      $display("FAIL watchdog run_req: got %b want %b", obs, exp_s);
    end
    run_req = 1'b0;
  endtask

  task automatic test_async_reset();
    #2;
    reset = 1'b1;
    push(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    #1;
    exp_s = sb.pop_front();
    checks++;
    if (obs !== exp_s) begin
      errors++;
      $display("FAIL async_reset_run: got %b want %b", obs, exp_s);
    end
    tick();
    reset = 1'b0;
    run_bringup("async_bringup", RC + SC);
    #2;
    reset = 1'b1;
    push(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    #1;
    exp_s = sb.pop_front();
    checks++;
    if (obs !== exp_s) begin
      errors++;
      $display("FAIL async_reset_start_pulse: got %b want %b", obs, exp_s);
    end
    tick();
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_run_collect();
    test_rerun();
    test_start_done();
    test_soft_reset();
    test_watchdog();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
